// File: rtl/stack_port_arbiter_if.sv
// Bundle of the two requester ports, the single-port stack memory port and
// the stack status outputs. The arbiter connects through the slave modport.
interface stack_port_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
);
   logic              r0_valid;
   logic              r0_op;
   logic [DATA_W-1:0] r0_wdata;
   logic              r0_ready;
   logic              r0_done;
   logic              r0_err;
   logic [DATA_W-1:0] r0_rdata;

   logic              r1_valid;
   logic              r1_op;
   logic [DATA_W-1:0] r1_wdata;
   logic              r1_ready;
   logic              r1_done;
   logic              r1_err;
   logic [DATA_W-1:0] r1_rdata;

   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic [ADDR_W:0]   sp;
   logic              empty;
   logic              full;
   logic              busy;

   modport slave (
      input  r0_valid, r0_op, r0_wdata, r1_valid, r1_op, r1_wdata, mem_rdata,
      output r0_ready, r0_done, r0_err, r0_rdata,
      output r1_ready, r1_done, r1_err, r1_rdata,
      output mem_we, mem_re, mem_addr, mem_wdata,
      output sp, empty, full, busy
   );

   modport master (
      output r0_valid, r0_op, r0_wdata, r1_valid, r1_op, r1_wdata, mem_rdata,
      input  r0_ready, r0_done, r0_err, r0_rdata,
      input  r1_ready, r1_done, r1_err, r1_rdata,
      input  mem_we, mem_re, mem_addr, mem_wdata,
      input  sp, empty, full, busy
   );
endinterface

// File: rtl/stack_port_arbiter.sv
// Round-robin arbiter sharing one single-port stack memory between two
// requesters; owns the stack pointer and full/empty tracking.
module stack_port_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 7
) (
   input logic                clk,
   input logic                rst,
   stack_port_arbiter_if.slave bus
);

   typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, RESP} state_t;

   localparam logic [ADDR_W:0] SP_FULL = {1'b1, {ADDR_W{1'b0}}};

   state_t            state_q, state_d;
   logic [ADDR_W:0]   sp_q, sp_d;
   logic              rr_last_q, rr_last_d;
   logic              gnt_q, gnt_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              full_w;
   logic              empty_w;
   logic              gnt_id;
   logic              any_valid;
   logic              sel_op;
   logic [DATA_W-1:0] sel_wdata;
   logic [ADDR_W:0]   sp_m1;
   logic              resp_w;

   assign full_w  = (sp_q == SP_FULL);
   assign empty_w = (sp_q == '0);
   assign sp_m1   = sp_q - {{ADDR_W{1'b0}}, 1'b1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sp_q      <= '0;
         rr_last_q <= 1'b1;
         gnt_q     <= 1'b0;
         wdata_q   <= '0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         sp_q      <= sp_d;
         rr_last_q <= rr_last_d;
         gnt_q     <= gnt_d;
         wdata_q   <= wdata_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      any_valid = bus.r0_valid | bus.r1_valid;
      if (bus.r0_valid && bus.r1_valid) gnt_id = ~rr_last_q;
      else                              gnt_id = bus.r1_valid;
      sel_op    = gnt_id ? bus.r1_op    : bus.r0_op;
      sel_wdata = gnt_id ? bus.r1_wdata : bus.r0_wdata;
   end

   always_comb begin
      state_d       = state_q;
      sp_d          = sp_q;
      rr_last_d     = rr_last_q;
      gnt_d         = gnt_q;
      wdata_d       = wdata_q;
      err_d         = err_q;
      rdata_d       = rdata_q;
      bus.r0_ready  = 1'b0;
      bus.r1_ready  = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;

      unique case (state_q)
         IDLE: begin
            if (any_valid) begin
               bus.r0_ready = ~gnt_id;
               bus.r1_ready = gnt_id;
               gnt_d        = gnt_id;
               rr_last_d    = gnt_id;
               wdata_d      = sel_wdata;
               rdata_d      = '0;
               // Overflow/underflow skip the memory and answer directly.
               if (sel_op ? full_w : empty_w) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = sel_op ? WRITE : READ;
               end
            end
         end
         WRITE: begin
            bus.mem_we    = 1'b1;
            bus.mem_addr  = sp_q[ADDR_W-1:0];
            bus.mem_wdata = wdata_q;
            sp_d          = sp_q + {{ADDR_W{1'b0}}, 1'b1};
            state_d       = RESP;
         end
         READ: begin
            bus.mem_re   = 1'b1;
            bus.mem_addr = sp_m1[ADDR_W-1:0];
            sp_d         = sp_m1;
            state_d      = RWAIT;
         end
         RWAIT: begin
            rdata_d = bus.mem_rdata;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign resp_w       = (state_q == RESP);
   assign bus.r0_done  = resp_w & ~gnt_q;
   assign bus.r1_done  = resp_w &  gnt_q;
   assign bus.r0_err   = bus.r0_done & err_q;
   assign bus.r1_err   = bus.r1_done & err_q;
   assign bus.r0_rdata = bus.r0_done ? rdata_q : '0;
   assign bus.r1_rdata = bus.r1_done ? rdata_q : '0;

   assign bus.sp    = sp_q;
   assign bus.empty = empty_w;
   assign bus.full  = full_w;
   assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_stack_port_arbiter.sv
// Directed bench for stack_port_arbiter with a behavioural 128x8 memory.
module tb_stack_port_arbiter;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   int   we_cnt, re_cnt, d0_cnt, d1_cnt;
   logic [6:0] last_we_addr, last_re_addr;
   logic [7:0] last_we_data;
   logic [7:0] mem [128];

   stack_port_arbiter_if #(.DATA_W(8), .ADDR_W(7)) bus ();

   stack_port_arbiter #(.DATA_W(8), .ADDR_W(7)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
   end

   // Strobe/done activity observer with exclusivity checks.
   always @(negedge clk) begin
      if (bus.mem_we) begin
         we_cnt++;
         last_we_addr = bus.mem_addr;
         last_we_data = bus.mem_wdata;
      end
      if (bus.mem_re) begin
         re_cnt++;
         last_re_addr = bus.mem_addr;
      end
      if (bus.r0_done) d0_cnt++;
      if (bus.r1_done) d1_cnt++;
      if (bus.mem_we || bus.mem_re || bus.r0_done || bus.r1_done) begin
         checks++;
         assert (!(bus.mem_we && bus.mem_re) && !(bus.r0_done && bus.r1_done)) else begin
            errors++;
            $error("FAIL exclusive: we=%0b re=%0b d0=%0b d1=%0b required no overlap",
                   bus.mem_we, bus.mem_re, bus.r0_done, bus.r1_done);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input int id, input logic op, input logic [7:0] d,
                      output logic err, output logic [7:0] rd, output int lat);
      int n;
      if (id == 0) begin
         bus.r0_valid = 1'b1; bus.r0_op = op; bus.r0_wdata = d;
      end else begin
         bus.r1_valid = 1'b1; bus.r1_op = op; bus.r1_wdata = d;
      end
      #1;
      n = 0;
      while (!(id == 0 ? bus.r0_ready : bus.r1_ready) && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
      tick();
      bus.r0_valid = 1'b0; bus.r0_op = 1'b0; bus.r0_wdata = '0;
      bus.r1_valid = 1'b0; bus.r1_op = 1'b0; bus.r1_wdata = '0;
      lat = 1;
      while (!(id == 0 ? bus.r0_done : bus.r1_done) && lat < 10) begin
         tick();
         lat++;
      end
      err = (id == 0) ? bus.r0_err   : bus.r1_err;
      rd  = (id == 0) ? bus.r0_rdata : bus.r1_rdata;
   endtask

   initial begin
      logic       err;
      logic [7:0] rd;
      int         lat;
      int         n;
      int         saved;
      int         g;

      checks = 0; errors = 0;
      we_cnt = 0; re_cnt = 0; d0_cnt = 0; d1_cnt = 0;
      bus.r0_valid = 1'b0; bus.r0_op = 1'b0; bus.r0_wdata = '0;
      bus.r1_valid = 1'b0; bus.r1_op = 1'b0; bus.r1_wdata = '0;
      bus.mem_rdata = '0;
      rst = 1'b1;
      #1;
      chk("rst_sp", 32'(bus.sp), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", {30'd0, bus.r0_done, bus.r1_done}, 32'd0);
      chk("rst_we_re", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // r0 push 0xA5, cycle by cycle
      bus.r0_valid = 1'b1; bus.r0_op = 1'b1; bus.r0_wdata = 8'hA5;
      #1;
      chk("push_r0_ready", 32'(bus.r0_ready), 32'd1);
      chk("push_r1_ready", 32'(bus.r1_ready), 32'd0);
      tick();
      bus.r0_valid = 1'b0; bus.r0_op = 1'b0; bus.r0_wdata = '0;
      chk("push_we", 32'(bus.mem_we), 32'd1);
      chk("push_addr", 32'(bus.mem_addr), 32'd0);
      chk("push_wdata", 32'(bus.mem_wdata), 32'hA5);
      chk("push_busy", 32'(bus.busy), 32'd1);
      tick();
      chk("push_done", 32'(bus.r0_done), 32'd1);
      chk("push_err", 32'(bus.r0_err), 32'd0);
      chk("push_rdata", 32'(bus.r0_rdata), 32'd0);
      chk("push_r1_done", 32'(bus.r1_done), 32'd0);
      chk("push_sp", 32'(bus.sp), 32'd1);
      chk("push_empty", 32'(bus.empty), 32'd0);
      tick();
      chk("push_done_end", 32'(bus.r0_done), 32'd0);
      chk("push_idle", 32'(bus.busy), 32'd0);

      // r1 pop returns 0xA5
      saved = re_cnt;
      req(1, 1'b0, 8'h00, err, rd, lat);
      chk("pop_lat", 32'(lat), 32'd3);
      chk("pop_rdata", 32'(rd), 32'hA5);
      chk("pop_err", 32'(err), 32'd0);
      chk("pop_re_cnt", 32'(re_cnt - saved), 32'd1);
      chk("pop_re_addr", 32'(last_re_addr), 32'd0);
      chk("pop_sp", 32'(bus.sp), 32'd0);
      chk("pop_empty", 32'(bus.empty), 32'd1);
      tick();
      chk("pop_rdata_idle", 32'(bus.r1_rdata), 32'd0);

      // underflow
      saved = re_cnt;
      req(0, 1'b0, 8'h00, err, rd, lat);
      chk("uflow_lat", 32'(lat), 32'd1);
      chk("uflow_err", 32'(err), 32'd1);
      chk("uflow_rdata", 32'(rd), 32'd0);
      chk("uflow_no_re", 32'(re_cnt - saved), 32'd0);
      chk("uflow_sp", 32'(bus.sp), 32'd0);
      tick();
      chk("uflow_err_idle", 32'(bus.r0_err), 32'd0);

      // fill, overflow, drain in LIFO order
      for (int unsigned i = 0; i < 128; i++) begin
         req(0, 1'b1, 8'(i), err, rd, lat);
         chk("fill_err", 32'(err), 32'd0);
         tick();
      end
      chk("fill_full", 32'(bus.full), 32'd1);
      chk("fill_sp", 32'(bus.sp), 32'd128);
      chk("fill_empty", 32'(bus.empty), 32'd0);
      saved = we_cnt;
      req(0, 1'b1, 8'hFF, err, rd, lat);
      chk("oflow_lat", 32'(lat), 32'd1);
      chk("oflow_err", 32'(err), 32'd1);
      chk("oflow_no_we", 32'(we_cnt - saved), 32'd0);
      chk("oflow_sp", 32'(bus.sp), 32'd128);
      tick();
      for (int unsigned i = 0; i < 128; i++) begin
         req(1, 1'b0, 8'h00, err, rd, lat);
         chk("drain_rdata", 32'(rd), 32'(127 - i));
         chk("drain_err", 32'(err), 32'd0);
         tick();
      end
      chk("drain_empty", 32'(bus.empty), 32'd1);
      chk("drain_sp", 32'(bus.sp), 32'd0);

      // both requesters pushing continuously; r1 won last, so r0 first
      bus.r0_valid = 1'b1; bus.r0_op = 1'b1; bus.r0_wdata = 8'h10;
      bus.r1_valid = 1'b1; bus.r1_op = 1'b1; bus.r1_wdata = 8'h20;
      #1;
      for (int unsigned k = 0; k < 6; k++) begin
         bus.r0_wdata = 8'(8'h10 + k);
         bus.r1_wdata = 8'(8'h20 + k);
         #1;
         n = 0;
         while (!(bus.r0_ready || bus.r1_ready) && n < 20) begin
            tick();
            n++;
         end
         chk("arb_both_ready", 32'(bus.r0_ready & bus.r1_ready), 32'd0);
         g = bus.r1_ready ? 1 : 0;
         chk("arb_grant", 32'(g), 32'(k % 2));
         tick();
         n = 0;
         while (!(bus.r0_done || bus.r1_done) && n < 10) begin
            tick();
            n++;
         end
         chk("arb_done_granted", 32'(g == 1 ? bus.r1_done : bus.r0_done), 32'd1);
         chk("arb_done_other", 32'(g == 1 ? bus.r0_done : bus.r1_done), 32'd0);
         tick();
      end
      bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
      bus.r0_op = 1'b0; bus.r1_op = 1'b0;
      chk("arb_sp", 32'(bus.sp), 32'd6);
      chk("arb_last_data", 32'(last_we_data), 32'h25);
      chk("arb_last_addr", 32'(last_we_addr), 32'd5);

      // reset during RWAIT of a pop
      bus.r0_valid = 1'b1; bus.r0_op = 1'b0;
      #1;
      chk("abort_ready", 32'(bus.r0_ready), 32'd1);
      tick();
      bus.r0_valid = 1'b0;
      chk("abort_re", 32'(bus.mem_re), 32'd1);
      chk("abort_re_addr", 32'(bus.mem_addr), 32'd5);
      tick();
      chk("abort_rwait_busy", 32'(bus.busy), 32'd1);
      saved = d0_cnt;
      rst = 1'b1;
      #1;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_sp", 32'(bus.sp), 32'd0);
      chk("abort_empty", 32'(bus.empty), 32'd1);
      chk("abort_done", {30'd0, bus.r0_done, bus.r1_done}, 32'd0);
      chk("abort_we_re", {30'd0, bus.mem_we, bus.mem_re}, 32'd0);
      tick(); tick();
      rst = 1'b0;
      tick(); tick();
      chk("abort_no_done", 32'(d0_cnt - saved), 32'd0);

      // first request after reset: r0 wins a tie again
      bus.r0_valid = 1'b1; bus.r0_op = 1'b1; bus.r0_wdata = 8'h3C;
      bus.r1_valid = 1'b1; bus.r1_op = 1'b1; bus.r1_wdata = 8'hC3;
      #1;
      chk("post_r0_ready", 32'(bus.r0_ready), 32'd1);
      chk("post_r1_ready", 32'(bus.r1_ready), 32'd0);
      tick();
      bus.r0_valid = 1'b0; bus.r1_valid = 1'b0;
      chk("post_we", 32'(bus.mem_we), 32'd1);
      chk("post_addr", 32'(bus.mem_addr), 32'd0);
      chk("post_wdata", 32'(bus.mem_wdata), 32'h3C);
      tick();
      chk("post_done", 32'(bus.r0_done), 32'd1);
      chk("post_sp", 32'(bus.sp), 32'd1);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stack_port_arbiter.md
Name: stack_port_arbiter

Overview:
Controller that shares one stack storage array between two independent requesters (host pin interface and an internal engine). It arbitrates push/pop requests round-robin and owns the stack pointer and full/empty tracking. It sequences the single-port memory (write, read with 1-cycle latency) and returns data and error status per request. Sits between the top-level I/O decode and the stack memory array.

Parameters:
DATA_W, 8, stack word width
ADDR_W, 7, memory address width; DEPTH = 2**ADDR_W entries (128)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
r0_valid  in  1  requester 0 request valid; held until r0_ready
r0_op  in  1  requester 0 operation: 1=push, 0=pop
r0_wdata  in  DATA_W  requester 0 push data
r0_ready  out  1  requester 0 request accepted this cycle
r0_done  out  1  one-cycle pulse: requester 0 operation complete
r0_err  out  1  valid with r0_done: overflow/underflow, no stack change
r0_rdata  out  DATA_W  pop data, valid with r0_done (0 on push or error)
r1_valid, r1_op, r1_wdata, r1_ready, r1_done, r1_err, r1_rdata  same as r0_* for requester 1
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re
sp  out  ADDR_W+1  stack pointer = number of valid entries (0..DEPTH)
empty  out  1  sp == 0
full  out  1  sp == DEPTH
busy  out  1  state != IDLE

Behaviour:
- Reset (async, immediate): state=IDLE, sp=0, rr_last=1 (r0 wins first tie), all strobes/ready/done/err/rdata = 0; empty=1, full=0, busy=0. Reset mid-operation aborts it: no done pulse, mem_we drops asynchronously, memory contents not guaranteed for the aborted write.
- States: IDLE, WRITE, READ, RWAIT, RESP.
- IDLE: grant = only valid requester; if both valid, the one not equal to rr_last. rN_ready asserted combinationally for the granted requester only. On valid&ready: latch op, wdata, grant id; rr_last <= grant id.
  - push, not full -> WRITE; push, full -> RESP with err=1.
  - pop, not empty -> READ; pop, empty -> RESP with err=1.
- WRITE (1 cycle): mem_we=1, mem_addr=sp[ADDR_W-1:0], mem_wdata=latched data; sp <= sp+1; -> RESP.
- READ (1 cycle): mem_re=1, mem_addr=sp-1; sp <= sp-1; -> RWAIT.
- RWAIT (1 cycle): capture mem_rdata into response register; -> RESP.
- RESP (1 cycle): rN_done=1 for granted requester, rN_err and rN_rdata driven from registers; other requester's done=0. -> IDLE.
- Latency accept->done: push 2 cycles, pop 3 cycles, error 1 cycle. No new request accepted before return to IDLE; back-to-back throughput: one op per 3 (push) / 4 (pop) cycles.
- rN_rdata/rN_err hold value only during done pulse; 0 otherwise.
- Errored request changes neither sp nor memory; arbitration still updates rr_last.
- Requester may drop valid before ready with no effect; op/wdata sampled only on accept cycle.
- mem_we and mem_re never both high; both low outside WRITE/READ.
- sp arithmetic in ADDR_W+1 bits; never wraps (guarded by full/empty checks). Address at sp=DEPTH never issued.

Test Plan:
- Reset then r0 push 0xA5 -> r0_ready same cycle, mem_we with addr 0/data 0xA5 next cycle, r0_done 2 cycles after accept, sp=1, empty=0.
- r1 pop after above -> mem_re addr 0, r1_done 3 cycles after accept with r1_rdata=0xA5, r1_err=0, sp=0, empty=1.
- Pop on empty stack from r0 -> r0_done one cycle after accept, r0_err=1, r0_rdata=0, no mem_re, sp stays 0.
- 128 pushes (values 0..127) then 129th push -> full=1 after 128th; 129th gets err=1, no mem_we; then 128 pops return 127..0 in LIFO order.
- r0 and r1 both valid continuously with pushes -> grants alternate r0,r1,r0,r1...; each done pulse only on the granted requester.
- Assert rst during RWAIT of a pop -> all outputs 0 immediately, no done pulse, sp=0, empty=1; next request after release behaves as first.
